id_stage: RTL

Instruction-decode stage of the RV32I pipeline, directly downstream of the fetch stage. Consumes the fetched instruction word and its PC, decodes fields and control, reads a 32x32 register file (written by write-back), generates the immediate, and registers everything into the ID/EX pipeline register. Detects load-use hazards and stalls fetch through `PC_Write`/`IR_Write`; inserts bubbles on stall or on an EX-stage flush.

---
 rtl/id_stage.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: field/control decode, immediate generation, 32x32 register
// file, load-use hazard stall and ID/EX pipeline register. Optional macro REGFILE_BYPASS_EN.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] pc_in,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        PC_Write,
  output logic        IR_Write,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [3:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic        ex_mem_to_reg,
  output logic        ex_branch,
  output logic        ex_jump
);

  typedef enum logic [6:0] {
    OpLoad   = 7'b0000011,
    OpOpImm  = 7'b0010011,
    OpAuipc  = 7'b0010111,
    OpStore  = 7'b0100011,
    OpOp     = 7'b0110011,
    OpLui    = 7'b0110111,
    OpBranch = 7'b1100011,
    OpJalr   = 7'b1100111,
    OpJal    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    ImmNone,
    ImmI,
    ImmS,
    ImmB,
    ImmU,
    ImmJ
  } imm_sel_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
  } idex_t;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  // Control decode
  imm_sel_e   imm_sel;
  logic [3:0] alu_op;
  logic       alu_src;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       mem_to_reg;
  logic       branch;
  logic       jump;
  logic       use_rs1;
  logic       use_rs2;

  always_comb begin
    imm_sel    = ImmNone;
    alu_op     = 4'b0000;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    use_rs1    = 1'b1;
    use_rs2    = 1'b0;
    case (opcode_e'(opcode))
      OpOp: begin
        alu_op    = {funct7[5], funct3};
        reg_write = 1'b1;
        use_rs2   = 1'b1;
      end
      OpOpImm: begin
        // funct7[5] only distinguishes SRAI from SRLI; elsewhere it is immediate data
        alu_op    = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
        imm_sel   = ImmI;
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      OpLoad: begin
        imm_sel    = ImmI;
        alu_src    = 1'b1;
        mem_read   = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      OpStore: begin
        imm_sel   = ImmS;
        alu_src   = 1'b1;
        mem_write = 1'b1;
        use_rs2   = 1'b1;
      end
      OpBranch: begin
        imm_sel = ImmB;
        alu_op  = 4'b1000;
        branch  = 1'b1;
        use_rs2 = 1'b1;
      end
      OpJal: begin
        imm_sel   = ImmJ;
        alu_src   = 1'b1;
        reg_write = 1'b1;
        jump      = 1'b1;
        use_rs1   = 1'b0;
      end
      OpJalr: begin
        imm_sel   = ImmI;
        alu_src   = 1'b1;
        reg_write = 1'b1;
        jump      = 1'b1;
      end
      OpLui, OpAuipc: begin
        imm_sel   = ImmU;
        alu_src   = 1'b1;
        reg_write = 1'b1;
        use_rs1   = 1'b0;
      end
      default: ;
    endcase
  end

  // Immediate generation
  logic [31:0] imm;

  always_comb begin
    imm = '0;
    case (imm_sel)
      ImmI:    imm = {{20{inst[31]}}, inst[31:20]};
      ImmS:    imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      ImmB:    imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      ImmU:    imm = {inst[31:12], 12'b0};
      ImmJ:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // Register file
  logic [31:0] rf_q [32];
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_we && (wb_rd != 5'd0)) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    rs2_data = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
`ifdef REGFILE_BYPASS_EN
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1)) rs1_data = wb_data;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2)) rs2_data = wb_data;
`endif
  end

  // Load-use hazard; flush wins because the stalled instruction is squashed anyway
  idex_t idex_q;
  idex_t idex_d;
  logic  hazard;
  logic  stall;
  logic  bubble;

  assign hazard = idex_q.valid && idex_q.mem_read && (idex_q.rd != 5'd0) &&
                  ((use_rs1 && (idex_q.rd == rs1)) || (use_rs2 && (idex_q.rd == rs2)));
  assign stall    = hazard && !flush;
  assign bubble   = hazard || flush;
  assign PC_Write = !stall;
  assign IR_Write = !stall;

  // ID/EX pipeline register
  always_comb begin
    idex_d = '0;
    if (!bubble) begin
      idex_d.valid      = 1'b1;
      idex_d.pc         = pc_in;
      idex_d.rs1_data   = rs1_data;
      idex_d.rs2_data   = rs2_data;
      idex_d.imm        = imm;
      idex_d.rs1        = rs1;
      idex_d.rs2        = rs2;
      idex_d.rd         = rd;
      idex_d.alu_op     = alu_op;
      idex_d.alu_src    = alu_src;
      idex_d.mem_read   = mem_read;
      idex_d.mem_write  = mem_write;
      idex_d.reg_write  = reg_write;
      idex_d.mem_to_reg = mem_to_reg;
      idex_d.branch     = branch;
      idex_d.jump       = jump;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign ex_valid      = idex_q.valid;
  assign ex_pc         = idex_q.pc;
  assign ex_rs1_data   = idex_q.rs1_data;
  assign ex_rs2_data   = idex_q.rs2_data;
  assign ex_imm        = idex_q.imm;
  assign ex_rs1        = idex_q.rs1;
  assign ex_rs2        = idex_q.rs2;
  assign ex_rd         = idex_q.rd;
  assign ex_alu_op     = idex_q.alu_op;
  assign ex_alu_src    = idex_q.alu_src;
  assign ex_mem_read   = idex_q.mem_read;
  assign ex_mem_write  = idex_q.mem_write;
  assign ex_reg_write  = idex_q.reg_write;
  assign ex_mem_to_reg = idex_q.mem_to_reg;
  assign ex_branch     = idex_q.branch;
  assign ex_jump       = idex_q.jump;

endmodule
